// File: rtl/catraca_pkg.sv
// catraca_pkg: shared constants, FSM state type and saturating balance update
package catraca_pkg;
  localparam int NPASS = 4;
  localparam int BAL_W = 3;
  localparam int BAL_MAX = 5;
  localparam int REC_W = 2;
  localparam int FARE = 1;
  localparam int OPEN_CYCLES = 4;
  localparam int IW = $clog2(NPASS);
  localparam int TW = $clog2(OPEN_CYCLES + 1);
  localparam int BW1 = BAL_W + 1;
  typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCK} state_t;
  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] bal, input logic debit,
                                               input logic [REC_W-1:0] rec);
    logic [BW1-1:0] s;
    s = {1'b0, bal} - (debit ? BW1'(FARE) : '0) + BW1'(rec);
    return s > BW1'(BAL_MAX) ? BAL_W'(BAL_MAX) : s[BAL_W-1:0];
  endfunction
endpackage

// File: rtl/catraca_arbiter_if.sv
// catraca_arbiter_if: card-reader/turnstile signal bundle between board wrapper and arbiter
interface catraca_arbiter_if;
  import catraca_pkg::*;
  logic [NPASS-1:0] req;
  logic [NPASS*REC_W-1:0] carrega;
  logic giro;
  logic catraca;
  logic [NPASS-1:0] grant;
  logic negado;
  logic [BAL_W-1:0] conta;
  logic busy;
  modport master(output req, carrega, giro, input catraca, grant, negado, conta, busy);
  modport slave(input req, carrega, giro, output catraca, grant, negado, conta, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic found;
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found = 1'b1;
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/catraca_arbiter.sv
// catraca_arbiter: round-robin turnstile controller with per-passenger saturating balances
module catraca_arbiter
  import catraca_pkg::*;
(
  input logic clk_2,
  input logic reset,
  catraca_arbiter_if.slave bus
);
  state_t state, nxt;
  logic [NPASS-1:0] gnt_c, grant_q;
  logic [IW-1:0] idx_c, w, rr;
  logic [TW-1:0] timer;
  logic [BAL_W-1:0] bal [NPASS];
  logic [BAL_W-1:0] conta_q;
  logic negado_q, ok;
  rr_arbiter #(.N(NPASS)) u_rr (.req(bus.req), .ptr(rr), .grant(gnt_c), .idx(idx_c));
  always_comb begin
    ok = bal[w] >= BAL_W'(FARE);
    nxt = state;
    case (state)
      IDLE:    nxt = |bus.req ? CHECK : IDLE;
      CHECK:   nxt = ok ? OPEN : IDLE;
      OPEN:    nxt = (bus.giro || timer == TW'(OPEN_CYCLES - 1)) ? LOCK : OPEN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state <= IDLE;
      w <= '0;
      rr <= '0;
      timer <= '0;
      grant_q <= '0;
      negado_q <= 1'b0;
      conta_q <= '0;
      for (int i = 0; i < NPASS; i++) bal[i] <= '0;
    end else begin
      state <= nxt;
      timer <= state == OPEN ? timer + TW'(1) : '0;
      negado_q <= state == CHECK && !ok;
      // decision uses pre-update balance, so a same-cycle recharge cannot rescue a refusal
      for (int i = 0; i < NPASS; i++)
        bal[i] <= sat_add(bal[i], state == CHECK && ok && w == IW'(i), bus.carrega[i*REC_W +: REC_W]);
      if (state == IDLE) begin
        w <= idx_c;
        grant_q <= gnt_c;
      end
      if (state == CHECK) begin
        rr <= w == IW'(NPASS - 1) ? '0 : w + IW'(1);
        conta_q <= ok ? bal[w] - BAL_W'(FARE) : bal[w];
      end
      if ((state == CHECK && !ok) || nxt == LOCK) grant_q <= '0;
    end
  end
  assign bus.catraca = state == OPEN;
  assign bus.busy = state != IDLE;
  assign bus.grant = grant_q;
  assign bus.negado = negado_q;
  assign bus.conta = conta_q;
endmodule

// File: doc/catraca_arbiter.md
Name: catraca_arbiter

Overview:
Shared-turnstile controller for the bus. It arbitrates card swipes from NPASS readers round-robin, keeps one saturating balance per passenger, and debits the fare. It then drives the turnstile release with a passage sensor and a timeout. It sits between the card-reader switches and the turnstile LED/7-segment outputs in the top-level board wrapper.

Parameters:
NPASS, 4, number of passengers/card readers
BAL_W, 3, balance width in bits
BAL_MAX, 5, balance saturation ceiling
REC_W, 2, per-passenger recharge input width
FARE, 1, amount debited per accepted passage
OPEN_CYCLES, 4, max cycles the turnstile stays released waiting for the sensor

Ports:
clk_2  in  1  system clock
reset  in  1  synchronous, active-low reset (sampled on posedge clk_2)
req  in  NPASS  req[i]=1: passenger i swiping card (level)
carrega  in  NPASS*REC_W  packed recharge amounts; slice i = passenger i
giro  in  1  turnstile rotation sensor, 1 = passage completed
catraca  out  1  1 = turnstile released
grant  out  NPASS  one-hot: passenger currently being served
negado  out  1  one-cycle pulse: swipe refused, insufficient balance
conta  out  BAL_W  balance of last served passenger after its transaction
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - all balances 0, state IDLE, rr pointer 0
  - catraca=0, grant=0, negado=0, conta=0, busy=0
  - Reset overrides any state, including mid-OPEN: catraca drops at that edge.
- States (registered, Moore outputs): IDLE, CHECK, OPEN, LOCK.
- IDLE:
  - If req != 0, pick the first set bit scanning from rr pointer upward, wrapping.
  - Latch winner w, grant <= onehot(w), go to CHECK.
  - If req == 0, stay.
- CHECK (exactly 1 cycle):
  - If bal[w] >= FARE: debit FARE, conta <= bal[w]-FARE, go to OPEN.
  - Else: negado <= 1 for one cycle, conta <= bal[w], grant <= 0, go to IDLE.
  - In both cases, rr pointer <= (w+1) mod NPASS.
- OPEN:
  - catraca=1; timer starts at 0 and increments each cycle.
  - giro==1 -> LOCK.
  - timer == OPEN_CYCLES-1 without giro -> LOCK; the fare is not refunded.
- LOCK (1 cycle cool-down): catraca=0, grant=0, req ignored, then go to IDLE.
- Latency: req seen at edge k -> grant high after k; catraca high after k+1; catraca low after the edge where giro is sampled plus 1 (LOCK).
- Requests are sampled only in IDLE. Requests in CHECK/OPEN/LOCK are ignored and not queued; a requester must hold req.
- Simultaneous requests: exactly one wins by round-robin. The others are served on later IDLE visits if still asserted.
- giro outside OPEN is ignored.
- Balance update for every i, every non-reset cycle: bal_i <= min(bal_i - debit_i + carrega_i, BAL_MAX).
  - Compute in BAL_W+1 bits; debit_i = FARE only for w in an accepting CHECK.
  - Recharge is independent of state; no passenger ever waits to recharge.
- The CHECK decision uses the pre-update balance. A recharge arriving in the same CHECK cycle does not rescue an insufficient balance.
- conta holds its value until the next CHECK or reset.

Decomposition:
- catraca_pkg: state enum (IDLE, CHECK, OPEN, LOCK), BAL_MAX, FARE, saturating-add function.
- Sub-module rr_arbiter: parameter N; inputs req and pointer; outputs one-hot grant and binary index. Purely combinational; the pointer register lives in catraca_arbiter.

Test Plan:
1. Reset low, then high, carrega0=2 for 1 cycle; req0=1 -> grant=0001 after 1 edge, catraca=1 after 2 edges, conta=1; giro=1 -> catraca=0 next edge, back to IDLE after LOCK.
2. bal1=0, req1=1 -> CHECK then negado=1 for exactly one cycle, conta=0, catraca never 1, balance stays 0.
3. bal0=bal2=3, req0=req2=1 held continuously -> served order 0, 2, 0, 2; each debit 1; final bal0=bal2=1.
4. bal3=4, carrega3=3 for one cycle -> bal3=5 (saturated); repeat -> stays 5; recharge during OPEN also applied.
5. Accepted swipe, giro never asserted -> catraca high exactly OPEN_CYCLES=4 cycles, then LOCK; balance remains debited.
6. reset=0 asserted during OPEN -> catraca=0, grant=0, all balances 0 at that edge; a req1 asserted in the same cycle is not granted.
